mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative signed MULT/DIV unit, the datapath-side responder to the control unit's multOP/divOP strobes.
//   Latches A/B operands on a start strobe and runs WIDTH shift-add (mult) or restoring (div) steps.
//   Writes the HI/LO pair, then pulses done.
//   Flags divide-by-zero back to the control unit for the exception path.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are WIDTH each, product is 2*WIDTH
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   reset         in   1      synchronous, active-high
//   mult_start    in   1      start signed multiply (multOP); sampled only in IDLE
//   div_start     in   1      start signed divide (divOP); sampled only in IDLE
//   a             in   WIDTH  operand A (multiplicand / dividend)
//   b             in   WIDTH  operand B (multiplier / divisor)
//   hi            out  WIDTH  mult: product[2W-1:W]; div: remainder
//   lo            out  WIDTH  mult: product[W-1:0]; div: quotient
//   busy          out  1      high from the edge after accepted start until done
//   done          out  1      one-cycle pulse; hi/lo valid from this cycle
//   div_by_zero   out  1      one-cycle pulse when div_start is accepted with b==0
// BEHAVIOUR
//   Reset: state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0. Reset mid-operation aborts and clears hi/lo.
//   States: IDLE, MULT, DIV, FIX, DONE.
//   IDLE, start edge (edge 0):
//     - latch |a|, |b|, the sign flags and the op.
//     - load counter=WIDTH-1.
//     - go to MULT or DIV; busy=1.
//   Priority in IDLE: mult_start over div_start when both are high; the divide is dropped.
//   Starts outside IDLE are ignored; no queueing.
//   div_start with b==0:
//     - stay in IDLE.
//     - div_by_zero=1 for the following cycle only; busy and done stay 0.
//     - hi/lo unchanged.
//   MULT: unsigned shift-add, one multiplier bit per cycle into a 2W-bit accumulator.
//   DIV: restoring division, one quotient bit per cycle; remainder register is W+1 bits to hold the trial subtract borrow.
//   Counter: decrements each MULT/DIV cycle; at 0 go to FIX, so exactly WIDTH iteration cycles.
//   FIX:
//     - mult: negate the 2W result if sign(a)!=sign(b).
//     - div: negate the quotient if sign(a)!=sign(b); negate the remainder if a<0 (truncate toward zero; remainder takes the dividend's sign).
//     - Write hi/lo on the FIX->DONE edge.
//   DONE: done=1 for one cycle, busy=0, then IDLE. A start presented during DONE is ignored.
//   Latency: done is high in the cycle after edge WIDTH+2, counting the accepting edge as edge 0.
//   hi/lo hold their value until the next completed operation; they are never written mid-iteration.
//   Boundary -2^(W-1) / -1: lo=0x80000000, hi=0. This is the raw magnitude result; no trap is raised, and overflow handling stays with the control unit.
//   Boundary -2^(W-1) * -2^(W-1): hi=0x40000000, lo=0.
//   Operands a/b may change after the start edge; the unit uses only latched copies.
// STRUCTURE
//   Package mult_div_pkg:
//     - state encoding (IDLE..DONE), op enum (OP_MULT, OP_DIV), default WIDTH.
//   One sub-module, md_sign_fix (combinational):
//     - abs of inputs, conditional negation of product/quotient/remainder.
//     - used at the latch stage and in FIX.
//   The iteration FSM, counter and accumulators stay in mult_div_unit.
// TESTING
//   1. mult a=7, b=-3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for WIDTH+2 cycles; done exactly one cycle.
//   2. mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0; mult a=0x7FFFFFFF, b=2 -> hi=0, lo=0xFFFFFFFE.
//   3. div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
//   4. div a=5, b=0 with hi/lo preloaded -> one div_by_zero pulse; no done; busy stays 0; hi/lo unchanged.
//   5. Stimulus: mult_start and div_start together; then a start pulse mid-op; then reset at iteration 10.
//      Required response:
//        - concurrent starts run the mult only;
//        - the mid-op start is ignored;
//        - reset gives busy=0, hi=lo=0, IDLE;
//        - a subsequent div 100/7 gives lo=14, hi=2.
//   6. div a=0x80000000, b=-1 -> lo=0x80000000, hi=0; no div_by_zero.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types for the iterative signed multiply/divide unit.
package mult_div_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

endpackage

// File: rtl/mult_div_if.sv
// Control-unit <-> mult/div handshake: start strobes, operands, results and status.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/md_sign_fix.sv
// Sign handling around the unsigned core: operand magnitudes on the way in,
// sign restoration of product / quotient / remainder on the way out.
module md_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_abs_a,
  output logic [WIDTH-1:0]   o_abs_b,
  input  md_op_e             i_op,
  input  logic               i_neg_a,
  input  logic               i_neg_b,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic               w_neg_res;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Magnitude of -2^(W-1) wraps to itself, which is the correct unsigned value.
  assign o_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign o_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

  assign w_neg_res = i_neg_a ^ i_neg_b;
  assign w_prod    = w_neg_res ? -i_acc : i_acc;
  assign w_quo     = w_neg_res ? -i_acc[WIDTH-1:0] : i_acc[WIDTH-1:0];
  // Remainder follows the dividend's sign (truncating division).
  assign w_rem     = i_neg_a ? -i_acc[2*WIDTH-1:WIDTH] : i_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (i_op == OP_DIV) begin
      o_hi = w_rem;
      o_lo = w_quo;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: one shift-add or restoring-divide step per cycle,
// sign correction in FIX, HI/LO written once per completed operation.
//
//   state | meaning
//   IDLE  | waiting for mult_start / div_start
//   MULT  | shift-add iteration, one multiplier bit per cycle
//   DIV   | restoring-divide iteration, one quotient bit per cycle
//   FIX   | sign-correct result, write hi/lo
//   DONE  | pulse done, drop busy, return to IDLE
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic     clk,
  input logic     reset,
  mult_div_if.slave bus
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  md_state_e          r_state;
  md_op_e             r_op;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH:0]     w_mult_sum;
  logic [2*WIDTH-1:0] w_mult_nxt;
  logic [2*WIDTH-1:0] w_div_sh;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_nxt;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_abs_a (w_abs_a),
    .o_abs_b (w_abs_b),
    .i_op    (r_op),
    .i_neg_a (r_neg_a),
    .i_neg_b (r_neg_b),
    .i_acc   (r_acc),
    .o_hi    (w_fix_hi),
    .o_lo    (w_fix_lo)
  );

  // Mult: acc = {partial product, remaining multiplier bits}; r_opb = multiplicand.
  assign w_mult_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mult_nxt = {w_mult_sum, r_acc[WIDTH-1:1]};

  // Div: acc = {remainder, dividend bits shifting into quotient}; r_opb = divisor.
  // Remainder < divisor <= 2^(W-1), so the shifted top bit is always zero and
  // the W+1-bit trial holds the borrow in its MSB.
  assign w_div_sh    = {r_acc[2*WIDTH-2:0], 1'b0};
  assign w_div_trial = {1'b0, w_div_sh[2*WIDTH-1:WIDTH]} - {1'b0, r_opb};
  assign w_div_nxt   = w_div_trial[WIDTH] ? w_div_sh
                                          : {w_div_trial[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= OP_MULT;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opb   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mult_start) begin
            r_op    <= OP_MULT;
            r_neg_a <= bus.a[WIDTH-1];
            r_neg_b <= bus.b[WIDTH-1];
            r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
            r_opb   <= w_abs_a;
            r_cnt   <= CNT_MAX;
            r_busy  <= 1'b1;
            r_state <= MULT;
          end else if (bus.div_start) begin
            if (bus.b == '0) begin
              r_dbz <= 1'b1;
            end else begin
              r_op    <= OP_DIV;
              r_neg_a <= bus.a[WIDTH-1];
              r_neg_b <= bus.b[WIDTH-1];
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb   <= w_abs_b;
              r_cnt   <= CNT_MAX;
              r_busy  <= 1'b1;
              r_state <= DIV;
            end
          end
        end
        MULT: begin
          r_acc <= w_mult_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == '0) r_state <= FIX;
        end
        DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Issues a start (optionally both strobes), optionally re-pulses starts mid-op,
  // then checks timing, hi/lo and the single-cycle done.
  task automatic run_op(input string tag, input bit st_m, input bit st_d,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] want_hi, input logic [W-1:0] want_lo,
                        input bit mid_start);
    int busy_cnt = 0;
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.mult_start = st_m; bus.div_start = st_d;
    @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    check({tag, " no_dbz"}, 64'(bus.div_by_zero), 64'd0);
    for (int i = 0; i < 3 * W; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (i == 10) check({tag, " hold_mid"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
      if (mid_start && i == 10) begin
        bus.mult_start = 1'b1; bus.div_start = 1'b1;
      end else begin
        bus.mult_start = 1'b0; bus.div_start = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(W + 2));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 2));
    check({tag, " hi"}, 64'(bus.hi), 64'(want_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(want_lo));
    exp_hi = want_hi;
    exp_lo = want_lo;
    @(negedge clk);
    check({tag, " done_1cyc"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  task automatic run_dbz(input string tag, input logic [W-1:0] a);
    @(negedge clk);
    bus.a = a; bus.b = '0; bus.div_start = 1'b1;
    @(negedge clk);
    bus.div_start = 1'b0;
    check({tag, " dbz_pulse"}, {61'd0, bus.div_by_zero, bus.busy, bus.done}, 64'b100);
    @(negedge clk);
    check({tag, " dbz_clear"}, {61'd0, bus.div_by_zero, bus.busy, bus.done}, 64'b000);
    repeat (3) @(negedge clk);
    check({tag, " no_done"}, {62'd0, bus.busy, bus.done}, 64'd0);
    check({tag, " hilo_kept"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [W-1:0] ra, rb, mh, ml;
    bit is_div;
    reset = 1'b1;
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);

    run_op("mul_7_m3", 1, 0, 32'd7, -32'sd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0);
    run_op("mul_max_2", 1, 0, 32'h7FFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFE, 0);
    run_op("div_m7_2", 0, 1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_7_m2", 0, 1, 32'd7, -32'sd2, 32'h1, 32'hFFFFFFFD, 0);
    run_dbz("div_5_0", 32'd5);

    // both strobes together run the multiply; the mid-op strobes must be ignored
    run_op("both_starts", 1, 1, 32'd1000, 32'd3, 32'd0, 32'd3000, 1);

    @(negedge clk);
    bus.a = 32'd12345; bus.b = 32'd678; bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_mid flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    run_op("div_100_7", 0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);

    for (int n = 0; n < 40; n++) begin
      is_div = $urandom_range(0, 1) == 1;
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($signed($urandom_range(0, 40)) - 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($signed($urandom_range(0, 2000)) - 1000);
      if (is_div && rb == '0) begin
        run_dbz("rnd_dbz", ra);
      end else begin
        model(is_div, ra, rb, mh, ml);
        run_op(is_div ? "rnd_div" : "rnd_mul", !is_div, is_div, ra, rb, mh, ml, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
